// File: rtl/fp_align_unpack_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_unpack_if
// Brief    : Operand handshake and aligned-result bus for fp_align_unpack.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_align_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A_o;
  logic [31:0] B_o;
  logic        signA;
  logic        signB;
  logic        ANaN;
  logic        BNaN;
  logic        Ainf;
  logic        Binf;
  logic        Azero;
  logic        Bzero;
  logic        alignedSign;
  logic [31:0] alignedResult;
  logic        carryOut;
  logic [7:0]  exponentOut;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, A_o, B_o, signA, signB, ANaN, BNaN, Ainf, Binf,
           Azero, Bzero, alignedSign, alignedResult, carryOut, exponentOut
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, A_o, B_o, signA, signB, ANaN, BNaN, Ainf, Binf,
           Azero, Bzero, alignedSign, alignedResult, carryOut, exponentOut
  );
endinterface
`default_nettype wire

// File: rtl/fp_align_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_unpack
// Brief    : FP32 adder front end - classify, align (iterative sticky shift),
//            add/subtract magnitudes. Define FP_ALIGN_FTZ_EN to flush subnormals.
// Revision : 1.0 - initial release
// ============================================================================
module fp_align_unpack #(
  parameter int SHIFT_STEP = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fp_align_unpack_if.slave  bus
);

  localparam logic [5:0] c_STEP = 6'(SHIFT_STEP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   w_inReady;
  logic   w_outValid;

  logic [31:0] r_a, r_b;
  logic [31:0] r_aO, r_bO;
  logic        r_signA, r_signB;
  logic        r_aNaN, r_bNaN, r_aInf, r_bInf, r_aZero, r_bZero;
  logic        r_alignedSign;
  logic [31:0] r_alignedResult;
  logic        r_carryOut;
  logic [7:0]  r_exponentOut;

  logic [31:0] r_mBig, r_mSmall;
  logic        r_signBig;
  logic [7:0]  r_expBig;
  logic [5:0]  r_remaining;
  logic        r_special;

  // ---------------- classification of the captured operands ----------------
  logic [7:0]  w_expA, w_expB;
  logic [22:0] w_fracA, w_fracB;
  logic        w_nanA, w_nanB, w_infA, w_infB, w_zeroA, w_zeroB;
  logic [31:0] w_mA, w_mB;
  logic [7:0]  w_effA, w_effB;
  logic        w_bGreater;
  logic [7:0]  w_diff;
  logic [5:0]  w_rem;
  logic        w_special;

  assign w_expA  = r_a[30:23];
  assign w_expB  = r_b[30:23];
  assign w_fracA = r_a[22:0];
  assign w_fracB = r_b[22:0];

  assign w_nanA = (&w_expA) && (|w_fracA);
  assign w_nanB = (&w_expB) && (|w_fracB);
  assign w_infA = (&w_expA) && !(|w_fracA);
  assign w_infB = (&w_expB) && !(|w_fracB);
`ifdef FP_ALIGN_FTZ_EN
  assign w_zeroA = !(|w_expA);
  assign w_zeroB = !(|w_expB);
`else
  assign w_zeroA = !(|w_expA) && !(|w_fracA);
  assign w_zeroB = !(|w_expB) && !(|w_fracB);
`endif

  assign w_mA   = {(|w_expA), w_fracA, 8'h00};
  assign w_mB   = {(|w_expB), w_fracB, 8'h00};
  assign w_effA = (|w_expA) ? w_expA : 8'd1;
  assign w_effB = (|w_expB) ? w_expB : 8'd1;

  // Strict compare so an exact magnitude tie keeps A as the larger operand.
  assign w_bGreater = {w_expB, w_fracB} > {w_expA, w_fracA};
  assign w_diff     = w_bGreater ? (w_effB - w_effA) : (w_effA - w_effB);
  assign w_rem      = (w_diff > 8'd32) ? 6'd32 : w_diff[5:0];
  assign w_special  = w_nanA | w_nanB | w_infA | w_infB | w_zeroA | w_zeroB;

  // ---------------- shifter and adder ----------------
  logic [5:0]  w_step;
  logic [31:0] w_shifted;
  logic        w_lost;
  logic [32:0] w_sum;
  logic [31:0] w_sub;

  assign w_step    = (r_remaining < c_STEP) ? r_remaining : c_STEP;
  assign w_shifted = r_mSmall >> w_step;
  // Any bit that fell off the bottom is folded into the sticky position.
  assign w_lost    = ((w_shifted << w_step) != r_mSmall);
  assign w_sum     = {1'b0, r_mBig} + {1'b0, r_mSmall};
  assign w_sub     = r_mBig - r_mSmall;

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) w_nextState = UNPACK;
      end
      UNPACK: begin
        if (w_special || (w_rem == 6'd0)) w_nextState = ADD;
        else                              w_nextState = SHIFT;
      end
      SHIFT: begin
        if (r_remaining == w_step) w_nextState = ADD;
      end
      ADD: w_nextState = DONE;
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a             <= '0;
      r_b             <= '0;
      r_aO            <= '0;
      r_bO            <= '0;
      r_signA         <= 1'b0;
      r_signB         <= 1'b0;
      r_aNaN          <= 1'b0;
      r_bNaN          <= 1'b0;
      r_aInf          <= 1'b0;
      r_bInf          <= 1'b0;
      r_aZero         <= 1'b0;
      r_bZero         <= 1'b0;
      r_alignedSign   <= 1'b0;
      r_alignedResult <= '0;
      r_carryOut      <= 1'b0;
      r_exponentOut   <= '0;
      r_mBig          <= '0;
      r_mSmall        <= '0;
      r_signBig       <= 1'b0;
      r_expBig        <= '0;
      r_remaining     <= '0;
      r_special       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a <= bus.A;
            r_b <= bus.B;
          end
        end
        UNPACK: begin
          r_aO        <= r_a;
          r_bO        <= r_b;
          r_signA     <= r_a[31];
          r_signB     <= r_b[31];
          r_aNaN      <= w_nanA;
          r_bNaN      <= w_nanB;
          r_aInf      <= w_infA;
          r_bInf      <= w_infB;
          r_aZero     <= w_zeroA;
          r_bZero     <= w_zeroB;
          r_mBig      <= w_bGreater ? w_mB : w_mA;
          r_mSmall    <= w_bGreater ? w_mA : w_mB;
          r_signBig   <= w_bGreater ? r_b[31] : r_a[31];
          r_expBig    <= w_bGreater ? w_effB : w_effA;
          r_remaining <= w_rem;
          r_special   <= w_special;
        end
        SHIFT: begin
          r_mSmall    <= w_shifted | {31'd0, w_lost};
          r_remaining <= r_remaining - w_step;
        end
        ADD: begin
          if (r_special) begin
            r_alignedResult <= '0;
            r_carryOut      <= 1'b0;
            r_alignedSign   <= r_signA;
            r_exponentOut   <= '0;
          end else if (r_signA == r_signB) begin
            r_alignedResult <= w_sum[31:0];
            r_carryOut      <= w_sum[32];
            r_alignedSign   <= r_signBig;
            r_exponentOut   <= r_expBig;
          end else begin
            r_alignedResult <= w_sub;
            r_carryOut      <= 1'b0;
            r_alignedSign   <= (w_sub == 32'd0) ? 1'b0 : r_signBig;
            r_exponentOut   <= r_expBig;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = w_inReady;
  assign bus.out_valid     = w_outValid;
  assign bus.A_o           = r_aO;
  assign bus.B_o           = r_bO;
  assign bus.signA         = r_signA;
  assign bus.signB         = r_signB;
  assign bus.ANaN          = r_aNaN;
  assign bus.BNaN          = r_bNaN;
  assign bus.Ainf          = r_aInf;
  assign bus.Binf          = r_bInf;
  assign bus.Azero         = r_aZero;
  assign bus.Bzero         = r_bZero;
  assign bus.alignedSign   = r_alignedSign;
  assign bus.alignedResult = r_alignedResult;
  assign bus.carryOut      = r_carryOut;
  assign bus.exponentOut   = r_exponentOut;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_align_unpack
// Brief    : Directed-vector bench for fp_align_unpack with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_align_unpack;

  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_align_unpack_if bus();

  fp_align_unpack #(.SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] aO, bO;
    logic        sA, sB, aNaN, bNaN, aInf, bInf, aZero, bZero, sign, carry;
    logic [31:0] res;
    logic [7:0]  expo;
    int          lat;
  } exp_t;

  int   nChecks = 0;
  int   nPass   = 0;
  int   nFail   = 0;
  exp_t cur;
  logic curValid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end else begin
      nPass++;
    end
  endtask

  // Value-level model: magnitudes as integers, one-shot sticky alignment.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          ea, eb, effA, effB, d, dc;
    logic [63:0] ma, mb, big, sm, al, r;
    logic        aBig, special;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    e.aO = a; e.bO = b; e.sA = a[31]; e.sB = b[31];
    e.aNaN = (ea == 255) && (a[22:0] != 0);
    e.bNaN = (eb == 255) && (b[22:0] != 0);
    e.aInf = (ea == 255) && (a[22:0] == 0);
    e.bInf = (eb == 255) && (b[22:0] == 0);
`ifdef FP_ALIGN_FTZ_EN
    e.aZero = (ea == 0);
    e.bZero = (eb == 0);
`else
    e.aZero = (a[30:0] == 0);
    e.bZero = (b[30:0] == 0);
`endif
    ma   = ((ea != 0) ? 64'h8000_0000 : 64'd0) + (64'(a[22:0]) << 8);
    mb   = ((eb != 0) ? 64'h8000_0000 : 64'd0) + (64'(b[22:0]) << 8);
    effA = (ea == 0) ? 1 : ea;
    effB = (eb == 0) ? 1 : eb;
    aBig = (a[30:0] >= b[30:0]);
    special = e.aNaN | e.bNaN | e.aInf | e.bInf | e.aZero | e.bZero;
    if (special) begin
      e.res = 0; e.carry = 0; e.sign = e.sA; e.expo = 0; e.lat = 2;
    end else begin
      big = aBig ? ma : mb;
      sm  = aBig ? mb : ma;
      d   = aBig ? effA - effB : effB - effA;
      dc  = (d > 32) ? 32 : d;
      if (d >= 32) al = (sm != 0) ? 64'd1 : 64'd0;
      else         al = (sm >> d) | (((sm & ((64'd1 << d) - 1)) != 0) ? 64'd1 : 64'd0);
      if (e.sA == e.sB) begin
        r = big + al;
        e.res = r[31:0]; e.carry = r[32]; e.sign = e.sA;
      end else begin
        r = big - al;
        e.res = r[31:0]; e.carry = 0;
        e.sign = (r == 0) ? 1'b0 : (aBig ? e.sA : e.sB);
      end
      e.expo = 8'(aBig ? effA : effB);
      e.lat  = 2 + (dc + STEP - 1) / STEP;
    end
    return e;
  endfunction

  // Every cycle the result is presented it must match the model exactly.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      check("expected_txn", {63'd0, curValid}, 64'd1);
      check("in_ready_busy", bus.in_ready, 0);
      check("A_o", bus.A_o, cur.aO);
      check("B_o", bus.B_o, cur.bO);
      check("signs", {bus.signA, bus.signB}, {cur.sA, cur.sB});
      check("flags", {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero},
            {cur.aNaN, cur.bNaN, cur.aInf, cur.bInf, cur.aZero, cur.bZero});
      check("alignedResult", bus.alignedResult, cur.res);
      check("carryOut", bus.carryOut, cur.carry);
      check("alignedSign", bus.alignedSign, cur.sign);
      check("exponentOut", bus.exponentOut, cur.expo);
    end
  end

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input int hold, output int lat);
    cur = model(a, b);
    curValid = 1'b1;
    accept(a, b);
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    check("latency", lat, cur.lat);
    repeat (hold) @(posedge clk);
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("valid_dropped", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    curValid = 1'b0;
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_A_o", bus.A_o, 0);
    check("rst_result", {bus.carryOut, bus.alignedSign, bus.alignedResult}, 0);
    check("rst_exp", bus.exponentOut, 0);
    @(negedge clk) rst = 1'b0;

    run(32'h3F80_0000, 32'h3F80_0000, 0, lat);
    check("t1_lat", lat, 2);
    check("t1_carry", bus.carryOut, 1);
    check("t1_res", bus.alignedResult, 32'h0000_0000);
    check("t1_exp", bus.exponentOut, 8'h7F);
    check("t1_sign", bus.alignedSign, 0);

    run(32'h3F80_0000, 32'h3F00_0000, 0, lat);
    check("t2_lat", lat, 3);
    check("t2_res", bus.alignedResult, 32'hC000_0000);
    check("t2_carry", bus.carryOut, 0);

    run(32'h3F80_0000, 32'hBF80_0000, 0, lat);
    check("t3_res", bus.alignedResult, 32'h0000_0000);
    check("t3_sign", bus.alignedSign, 0);
    check("t3_exp", bus.exponentOut, 8'h7F);

    run(32'h3F80_0000, 32'h2F80_0000, 0, lat);
    check("t4_lat", lat, 10);
    check("t4_res", bus.alignedResult, 32'h8000_0001);

    run(32'h7FC0_0000, 32'h3F80_0000, 0, lat);
    check("t5_lat", lat, 2);
    check("t5_nan", bus.ANaN, 1);
    check("t5_A_o", bus.A_o, 32'h7FC0_0000);

    run(32'h7F80_0000, 32'hFF80_0000, 0, lat);
    check("t6_inf", {bus.Ainf, bus.Binf}, 2'b11);

    // -3 + 1 held in DONE for five cycles
    run(32'hC040_0000, 32'h3F80_0000, 5, lat);
    check("t7_res", bus.alignedResult, 32'h8000_0000);
    check("t7_sign", bus.alignedSign, 1);
    check("t7_exp", bus.exponentOut, 8'h80);

    run(32'h3F80_0000, 32'hC000_0000, 0, lat);
    check("t8_res", bus.alignedResult, 32'h4000_0000);
    check("t8_sign", bus.alignedSign, 1);

    run(32'h0000_0000, 32'h8000_0000, 0, lat);
    check("t9_zero", {bus.Azero, bus.Bzero}, 2'b11);

    run(32'h4049_0FDB, 32'h3DCC_CCCD, 1, lat);
    run(32'hC2F6_E979, 32'h42F6_E978, 0, lat);
    run(32'h0040_0000, 32'h0030_0000, 0, lat);

    run(32'h0000_0001, 32'h3F80_0000, 0, lat);
`ifdef FP_ALIGN_FTZ_EN
    check("t10_azero", bus.Azero, 1);
    check("t10_res", bus.alignedResult, 32'h0000_0000);
`else
    check("t10_azero", bus.Azero, 0);
    check("t10_lat", lat, 10);
    check("t10_res", bus.alignedResult, 32'h8000_0001);
`endif

    // Reset while the shifter is iterating aborts the operation.
    cur = model(32'h3F80_0000, 32'h2F80_0000);
    accept(32'h3F80_0000, 32'h2F80_0000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_A_o", bus.A_o, 0);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("abort_no_output", bus.out_valid, 0);

    run(32'h3F80_0000, 32'h3F00_0000, 0, lat);
    check("post_abort_res", bus.alignedResult, 32'hC000_0000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
